// File: rtl/modulator_am.sv
// modulator_am: PWM amplitude modulator that pops one FIFO sample per period and
// emits its duty-cycle-encoded bit alongside bclk, nsync and symb_clk framing clocks.
module modulator_am #(
    parameter int PARAMETER01 = 10,
    parameter int PARAMETER02 = 255,
    parameter int PARAMETER03 = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PARAMETER03-1:0] sample,
    input  logic                   empty,
    output logic                   read,
    output logic                   nsync,
    output logic                   bclk,
    output logic                   pwm,
    output logic                   symb_clk
);
    localparam int P1 = PARAMETER01;
    localparam int P2 = PARAMETER02;
    localparam int W  = PARAMETER03;
    localparam int N  = P1 * P2;
    localparam int PW = $clog2(P1);
    localparam int SW = $clog2(P2);
    localparam int CW = $clog2(N);
    localparam int MW = (W > SW) ? W : SW;

    logic [PW-1:0] p;
    logic [SW-1:0] s;
    logic [W-1:0]  sample_reg;
    logic          run;
    logic          p_last;
    logic          s_last;
    logic          load;
    logic [CW-1:0] c;

    assign p_last = p == PW'(P1 - 1);
    assign s_last = s == SW'(P2 - 1);
    assign load   = p_last & s_last;
    assign c      = CW'(s) * CW'(P1) + CW'(p);

    // Idle and reset both park the counters on the load cycle so restart pops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p          <= PW'(P1 - 1);
            s          <= SW'(P2 - 1);
            sample_reg <= '0;
            run        <= 1'b0;
        end else if (!enable) begin
            p   <= PW'(P1 - 1);
            s   <= SW'(P2 - 1);
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            p   <= p_last ? '0 : p + PW'(1);
            if (p_last)
                s <= s_last ? '0 : s + SW'(1);
            if (load)
                sample_reg <= empty ? '0 : sample;
        end
    end

    // At the load state bclk/nsync/symb_clk already decode to idle; only pwm needs gating.
    always_comb begin
        read     = rst & enable & load & ~empty;
        pwm      = run & (MW'(s) < MW'(sample_reg));
        nsync    = s != '0;
        bclk     = p < PW'(P1 / 2);
        symb_clk = c < CW'(N / 2);
    end
endmodule

// File: tb/tb_modulator_am.sv
// tb_modulator_am: directed vectors for modulator_am; a negedge monitor measures each
// PWM period and compares it against expected periods queued by the stimulus.
module tb_modulator_am;
    localparam int N = 2550;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] sample = 8'h00;
    logic       read, nsync, bclk, pwm, symb_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int pwm_hi;
        int reads;
    } exp_t;
    exp_t q[$];

    logic [7:0] vals[10] = '{8'h03, 8'h05, 8'h00, 8'h0F, 8'h02, 8'h02, 8'hFF, 8'hAA, 8'h01, 8'h04};
    bit         emps[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    always #5 clk = ~clk;

    modulator_am dut (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample), .empty(empty),
        .read(read), .nsync(nsync), .bclk(bclk), .pwm(pwm), .symb_clk(symb_clk)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_read"}, int'(read), 0);
        check({tag, "_pwm"}, int'(pwm), 0);
        check({tag, "_nsync"}, int'(nsync), 1);
        check({tag, "_bclk"}, int'(bclk), 0);
        check({tag, "_symb"}, int'(symb_clk), 0);
    endtask

    // Frame = nsync falling edge up to the cycle before the next one (includes the load cycle).
    logic prev_nsync = 1'b1;
    bit   in_period = 0;
    int   f_pwm, f_ns, f_sy, f_bc, f_rd, f_len;

    always @(negedge clk) begin
        if (!rst || !enable) begin
            in_period = 0;
        end else begin
            if (prev_nsync && !nsync) begin
                if (in_period) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got extra period expected none at %0t", $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("pwm_high", f_pwm, e.pwm_hi);
                        check("nsync_low", f_ns, 10);
                        check("symb_high", f_sy, 1275);
                        check("bclk_high", f_bc, 1275);
                        check("reads", f_rd, e.reads);
                        check("period_len", f_len, N);
                    end
                end
                in_period = 1;
                f_pwm = 0; f_ns = 0; f_sy = 0; f_bc = 0; f_rd = 0; f_len = 0;
            end
            if (in_period) begin
                f_pwm += int'(pwm);
                f_ns  += int'(!nsync);
                f_sy  += int'(symb_clk);
                f_bc  += int'(bclk);
                f_rd  += int'(read);
                f_len++;
            end
        end
        prev_nsync = nsync;
    end

    initial begin
        enable = 1'b1;
        empty  = 1'b0;
        sample = 8'h03;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("first_read", int'(read), 1);

        for (int i = 0; i < 9; i++)
            q.push_back('{pwm_hi: emps[i] ? 0 : int'(vals[i]) * 10, reads: emps[i+1] ? 0 : 1});

        for (int i = 0; i < 10; i++) begin
            sample = vals[i];
            empty  = emps[i];
            @(posedge clk);
            #1;
            if (i < 9) begin
                repeat (N - 1) @(posedge clk);
                #1;
            end
        end

        repeat (20) @(posedge clk);
        #1;
        check("pwm_pre_drop", int'(pwm), 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("disabled");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("disabled_read", int'(read), 0);

        sample = 8'h06;
        enable = 1'b1;
        #1;
        check("reenable_read", int'(read), 1);
        @(posedge clk);
        @(negedge clk);
        check("reenable_pwm", int'(pwm), 1);
        check("reenable_nsync", int'(nsync), 0);
        check("reenable_bclk", int'(bclk), 1);
        check("reenable_symb", int'(symb_clk), 1);

        repeat (30) @(posedge clk);
        #3;
        check("pre_reset_symb", int'(symb_clk), 1);
        rst = 1'b0;
        #1;
        check_idle("async_reset");

        sample = 8'h03;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("restart_read", int'(read), 1);
        q.push_back('{pwm_hi: 30, reads: 1});
        @(posedge clk);
        #1;
        repeat (N - 1) @(posedge clk);
        #1;
        sample = 8'h07;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("queue_left", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
